// File: rtl/multicycle_adder_pkg.sv
// Shared types and constants for the multi-cycle ripple-carry adder/subtractor.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/multicycle_adder_if.sv
// Operand request and result handshake bundle for multicycle_adder.
interface multicycle_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/multicycle_adder_rca_chunk.sv
// Combinational W-bit ripple-carry adder built from a chain of full adders; also exposes
// the carry into the top bit so the caller can derive signed overflow.
module rca_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic carry;

  always_comb begin
    carry = cin;
    c_msb = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i == W - 1) c_msb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock through one
// shared ripple-carry slice, carry held in a register between cycles.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input logic               clk,
  input logic               rst,
  multicycle_adder_if.slave bus
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0]  LastCnt   = CntW'(N - 1);
  localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

  if (WIDTH % CHUNK != 0) begin : gen_bad_cfg
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       shamt;
  logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_sum;
  logic              chunk_cout, chunk_cmsb;

  // Chunks are selected by shifting rather than indexing so any CHUNK/WIDTH ratio works.
  always_comb begin
    shamt   = 32'(cnt_q) * 32'(CHUNK);
    chunk_a = CHUNK'(a_q >> shamt);
    chunk_b = CHUNK'(b_q >> shamt);
  end

  rca_chunk #(
    .W(CHUNK)
  ) u_rca_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .c_msb(chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
          carry_d = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = (sum_q & ~(ChunkMask << shamt)) | (WIDTH'(chunk_sum) << shamt);
        carry_d = chunk_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cout_d  = chunk_cout;
          ovf_d   = chunk_cout ^ chunk_cmsb;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode the state register only, so they stay fully registered.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule
